mips_divider: RTL and testbench
===============================

Name: mips_divider

Overview:
- Iterative 32-bit restoring divider for the MIPS DIV/DIVU instructions, built on repeated trial subtraction.
- Sits beside the ALU/adder in the execute stage. The core stalls on `busy`, then writes `quotient` to LO and `remainder` to HI.
- Computes one quotient bit per clock: 32 iterations, plus sign fix-up folded into the completion cycle.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified; RTL must not hard-code 5-bit counter widths (use $clog2(WIDTH)+1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when not busy
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start
- dividend  input  WIDTH  numerator; latched with start
- divisor  input  WIDTH  denominator; latched with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: results valid
- quotient  output  WIDTH  result for LO
- remainder  output  WIDTH  result for HI
- div_zero  output  1  last completed op had divisor == 0; valid with done, held

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy, done, quotient, remainder, div_zero, iteration counter and working registers all 0. Any operation in flight is discarded.
- States:
  - IDLE: start=1 → latch operands, go to RUN; start=0 → stay.
  - RUN: one iteration per edge for WIDTH edges, then go to FIN.
  - FIN: apply sign fix-up, register outputs, pulse done, go to IDLE.
- Cycle timing: if start is sampled 1 at edge k:
  - busy=1 during cycles k+1 .. k+WIDTH+1.
  - done=1 exactly in the cycle after edge k+WIDTH+1; busy=0 in that cycle.
  - Total latency: 33 edges from accept to results.
- Back-to-back: start may be asserted in the same cycle done is high. It is accepted at that edge (IDLE) and the new op begins.
- start while busy: ignored, with no effect on the op in flight. Input operand changes while busy are ignored.
- quotient, remainder and div_zero hold their values until the next FIN. They are unchanged while a new op is running.
- Unsigned algorithm:
  - Working registers are a WIDTH-bit partial remainder R and a shift register Q.
  - Each iteration: shift {R,Q} left 1, then trial-subtract R − divisor at WIDTH+1 bits.
  - If the result is non-negative, R takes the difference and Q LSB = 1; otherwise R is restored and Q LSB = 0.
- Signed mode:
  - Operate on magnitudes.
  - Quotient negated iff operand signs differ; truncation toward zero.
  - Remainder takes the dividend's sign, and |remainder| < |divisor|.
  - Examples: −8/3 → q=−2, r=−2; 7/−2 → q=−3, r=1.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. No flag, no exception.
- Divide by zero (both modes):
  - q=all ones, r=dividend unmodified (no sign fix-up), div_zero=1.
  - Same latency as a normal op, unless the optional feature below is enabled.
- div_zero=0 for every op with a nonzero divisor.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: a zero divisor is detected at accept. The op skips RUN and goes IDLE→FIN, so done pulses in the cycle after edge k+1 (busy high for cycle k+1 only). Results are identical to the non-fast case.
- Undefined: zero divisor takes the full 33-edge path; results are as specified in Behaviour.

Test Plan:
- Unsigned 100 / 7, start at edge k → busy high 33 cycles, done pulse after edge k+33, q=14, r=2, div_zero=0.
- Signed −8 / 3 (0xFFFFFFF8, 0x3) → q=0xFFFFFFFE, r=0xFFFFFFFE.
  - Same operands unsigned → q=0x55555552, r=0x2.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0.
- Divide by zero, 5 / 0 → q=0xFFFFFFFF, r=5, div_zero=1.
  - Latency 33 edges without DIV_ZERO_FAST_EN; done after edge k+1 with it.
- Busy/back-to-back:
  - Pulse start with new operands mid-op → ignored; the first result is correct.
  - Assert start during the done cycle with 9/2 → accepted; done again 33 edges later, q=4, r=1.
- Reset mid-op: assert rst at iteration 10 → busy/done/q/r/div_zero=0 immediately (asynchronous). After release, a fresh 100/7 gives q=14, r=2.

Source files
------------

// File: rtl/mips_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: one quotient bit per clock, sign fix-up on completion.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iteration phase.
module mips_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0] a_mag, b_mag, diff;
  logic [WIDTH:0]   r_sh;
  logic             ge;

  // Magnitudes of the incoming operands and the per-iteration trial subtraction.
  always_comb begin
    a_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    b_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    r_sh  = {r_q, q_q[WIDTH-1]};
    ge    = (r_sh >= {1'b0, d_q});
    // True difference is below d_q whenever ge holds, so WIDTH bits suffice.
    diff  = r_sh[WIDTH-1:0] - d_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d     = '0;
          q_d     = a_mag;
          d_d     = b_mag;
          negq_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = is_signed & dividend[WIDTH-1];
          zero_d  = (divisor == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef DIV_ZERO_FAST_EN
          // Preload R with what the full iteration would have produced for a zero divisor.
          if (divisor == '0) begin
            r_d     = a_mag;
            state_d = S_FIN;
          end
`endif
        end
      end
      S_RUN: begin
        q_d   = {q_q[WIDTH-2:0], ge};
        r_d   = ge ? diff : r_sh[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        // For a zero divisor R holds |dividend|, so the remainder fix-up restores the raw dividend.
        quo_d   = zero_q ? '1 : (negq_q ? -q_q : q_q);
        rem_d   = negr_q ? -r_q : r_q;
        dz_d    = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_mips_divider.sv
// Self-checking bench for mips_divider: directed table, timing/corner sequences, random ops vs. arithmetic model.
module tb_mips_divider;

  logic        clk, rst, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  mips_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain integer division semantics (truncation toward zero).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Presents an op for one edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1; dividend = a; divisor = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom);
  endtask

  // Waits for done (bounded), checking busy throughout, latency and results.
  task automatic finish_op(input string name, input int n0, input int lat,
                           input logic [31:0] q, input logic [31:0] r, input logic dz);
    int  n = n0;
    bit  busy_ok = 1'b1;
    while (!done && n < 200) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({name, " q"}, quotient, q);
    check({name, " r"}, remainder, r);
    check({name, " dz"}, {31'd0, div_zero}, {31'd0, dz});
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] eq, er, a, b;
    logic        edz, s;

    tbl.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0});
    tbl.push_back('{32'hFFFF_FFF8,  32'd3,          1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFE,  1'b0});
    tbl.push_back('{32'hFFFF_FFF8,  32'd3,          1'b0, 32'h5555_5552,  32'd2,          1'b0});
    tbl.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0});
    tbl.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0});
    tbl.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1});
    tbl.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0});
    tbl.push_back('{32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1});
    tbl.push_back('{32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 32'd1,          32'h7FFF_FFFF,  1'b0});

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    #3;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset q", quotient, 32'd0);
    check("reset r", remainder, 32'd0);
    check("reset dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].s);
      finish_op($sformatf("vec%0d", i), 0, exp_lat(tbl[i].b), tbl[i].q, tbl[i].r, tbl[i].dz);
    end

    // Back-to-back: new op issued in the done cycle of 100/7.
    issue(32'd100, 32'd7, 1'b0);
    finish_op("b2b first", 0, 33, 32'd14, 32'd2, 1'b0);
    issue(32'd9, 32'd2, 1'b0);
    check("hold q during op", quotient, 32'd14);
    check("done one pulse", {31'd0, done}, 32'd0);
    finish_op("b2b second", 0, 33, 32'd4, 32'd1, 1'b0);

    // start pulsed with other operands mid-op is ignored.
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #1; start = 1'b1; dividend = 32'd9; divisor = 32'd2; is_signed = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    finish_op("ignored start", 6, 33, 32'd14, 32'd2, 1'b0);

    // Asynchronous reset mid-op.
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2; rst = 1'b1; #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst q", quotient, 32'd0);
    check("midrst r", remainder, 32'd0);
    check("midrst dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    issue(32'd100, 32'd7, 1'b0);
    finish_op("after rst", 0, 33, 32'd14, 32'd2, 1'b0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      s = 1'($urandom);
      model(a, b, s, eq, er, edz);
      issue(a, b, s);
      finish_op($sformatf("rand%0d", i), 0, exp_lat(b), eq, er, edz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
